// File: rtl/lsu_mem_arbiter.sv
// Round-robin arbiter sharing one LSU memory port between requesters A and B.
// One transaction in flight; the response is steered back by the owner-id bit of the tag.
module lsu_mem_arbiter #(
    parameter int MEMORY_BUS_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        a_rd_en,
    input  logic                        a_wr_en,
    input  logic [31:0]                 a_addr,
    input  logic [MEMORY_BUS_WIDTH-1:0] a_wr_data,
    input  logic [5:0]                  a_tag,
    input  logic                        a_gm_or_lds,
    output logic                        a_ack,
    output logic [MEMORY_BUS_WIDTH-1:0] a_rd_data,
    output logic [5:0]                  a_tag_resp,
    input  logic                        b_rd_en,
    input  logic                        b_wr_en,
    input  logic [31:0]                 b_addr,
    input  logic [MEMORY_BUS_WIDTH-1:0] b_wr_data,
    input  logic [5:0]                  b_tag,
    input  logic                        b_gm_or_lds,
    output logic                        b_ack,
    output logic [MEMORY_BUS_WIDTH-1:0] b_rd_data,
    output logic [5:0]                  b_tag_resp,
    output logic                        mem_rd_en,
    output logic                        mem_wr_en,
    output logic [31:0]                 mem_addr,
    output logic [MEMORY_BUS_WIDTH-1:0] mem_wr_data,
    output logic                        mem_gm_or_lds,
    output logic [6:0]                  mem_tag_req,
    input  logic                        mem_ack,
    input  logic [6:0]                  mem_tag_resp,
    input  logic [MEMORY_BUS_WIDTH-1:0] mem_rd_data,
    output logic                        arb_idle,
    output logic                        arb_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t state, state_next;
    logic   prio;   // 0 = A wins a tie, 1 = B wins a tie
    logic   owner;
    logic   a_v, b_v, gnt_b, grant, resp_ok, resp_bad;
    logic   sel_rd, sel_wr, sel_gm;
    logic [31:0]                 sel_addr;
    logic [MEMORY_BUS_WIDTH-1:0] sel_wdata;
    logic [5:0]                  sel_tag;

    always_comb begin
        a_v        = a_rd_en | a_wr_en;
        b_v        = b_rd_en | b_wr_en;
        gnt_b      = b_v & (~a_v | prio);
        grant      = 1'b0;
        resp_ok    = 1'b0;
        resp_bad   = 1'b0;
        state_next = state;
        case (state)
            IDLE: if (a_v | b_v) begin
                grant      = 1'b1;
                state_next = ISSUE;
            end
            ISSUE: if (mem_ack) begin
                if (mem_tag_resp[6] == owner) begin
                    resp_ok    = 1'b1;
                    state_next = RESP;
                end else begin
                    resp_bad = 1'b1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        sel_rd    = gnt_b ? b_rd_en     : a_rd_en;
        sel_wr    = gnt_b ? b_wr_en     : a_wr_en;
        sel_gm    = gnt_b ? b_gm_or_lds : a_gm_or_lds;
        sel_addr  = gnt_b ? b_addr      : a_addr;
        sel_wdata = gnt_b ? b_wr_data   : a_wr_data;
        sel_tag   = gnt_b ? b_tag       : a_tag;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    assign arb_idle = (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio          <= 1'b0;
            owner         <= 1'b0;
            mem_rd_en     <= 1'b0;
            mem_wr_en     <= 1'b0;
            mem_addr      <= '0;
            mem_wr_data   <= '0;
            mem_gm_or_lds <= 1'b0;
            mem_tag_req   <= '0;
            a_ack         <= 1'b0;
            b_ack         <= 1'b0;
            a_rd_data     <= '0;
            b_rd_data     <= '0;
            a_tag_resp    <= '0;
            b_tag_resp    <= '0;
            arb_err       <= 1'b0;
        end else begin
            a_ack <= 1'b0;
            b_ack <= 1'b0;
            if (grant) begin
                owner         <= gnt_b;
                mem_rd_en     <= sel_rd;
                mem_wr_en     <= sel_wr & ~sel_rd;
                mem_addr      <= sel_addr;
                mem_wr_data   <= sel_wdata;
                mem_gm_or_lds <= sel_gm;
                mem_tag_req   <= {gnt_b, sel_tag};
            end
            if (resp_ok) begin
                mem_rd_en <= 1'b0;
                mem_wr_en <= 1'b0;
                if (owner) begin
                    b_ack      <= 1'b1;
                    b_rd_data  <= mem_rd_data;
                    b_tag_resp <= mem_tag_resp[5:0];
                end else begin
                    a_ack      <= 1'b1;
                    a_rd_data  <= mem_rd_data;
                    a_tag_resp <= mem_tag_resp[5:0];
                end
            end
            // Whoever was just served loses the next tie.
            if (state == RESP) prio <= ~owner;
            if (resp_bad || (grant && sel_rd && sel_wr)) arb_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Bench for lsu_mem_arbiter: vector table, hand-written corner sequences and
// a randomized run against a transaction-level round-robin model.
module tb_lsu_mem_arbiter;

    localparam int MW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a_rd_en = 0, a_wr_en = 0, a_gm_or_lds = 0;
    logic [31:0] a_addr = 0;
    logic [MW-1:0] a_wr_data = 0;
    logic [5:0] a_tag = 0;
    logic a_ack;
    logic [MW-1:0] a_rd_data;
    logic [5:0] a_tag_resp;
    logic b_rd_en = 0, b_wr_en = 0, b_gm_or_lds = 0;
    logic [31:0] b_addr = 0;
    logic [MW-1:0] b_wr_data = 0;
    logic [5:0] b_tag = 0;
    logic b_ack;
    logic [MW-1:0] b_rd_data;
    logic [5:0] b_tag_resp;
    logic mem_rd_en, mem_wr_en, mem_gm_or_lds;
    logic [31:0] mem_addr;
    logic [MW-1:0] mem_wr_data;
    logic [6:0] mem_tag_req;
    logic mem_ack = 0;
    logic [6:0] mem_tag_resp = 0;
    logic [MW-1:0] mem_rd_data = 0;
    logic arb_idle, arb_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_mem_arbiter #(.MEMORY_BUS_WIDTH(MW)) dut (
        .clk(clk), .rst(rst),
        .a_rd_en(a_rd_en), .a_wr_en(a_wr_en), .a_addr(a_addr), .a_wr_data(a_wr_data),
        .a_tag(a_tag), .a_gm_or_lds(a_gm_or_lds), .a_ack(a_ack), .a_rd_data(a_rd_data),
        .a_tag_resp(a_tag_resp),
        .b_rd_en(b_rd_en), .b_wr_en(b_wr_en), .b_addr(b_addr), .b_wr_data(b_wr_data),
        .b_tag(b_tag), .b_gm_or_lds(b_gm_or_lds), .b_ack(b_ack), .b_rd_data(b_rd_data),
        .b_tag_resp(b_tag_resp),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_gm_or_lds(mem_gm_or_lds), .mem_tag_req(mem_tag_req),
        .mem_ack(mem_ack), .mem_tag_resp(mem_tag_resp), .mem_rd_data(mem_rd_data),
        .arb_idle(arb_idle), .arb_err(arb_err)
    );

    typedef struct {
        logic        rd, wr, gm;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [5:0]  tag;
    } req_t;

    typedef struct {
        bit          is_b;
        req_t        r;
        int          delay;
        logic [31:0] rdata;
        logic        exp_rd, exp_wr;
        logic [6:0]  exp_tagreq;
        logic        exp_err;
    } vec_t;

    req_t ra, rb;
    bit   pa, pb;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic drive();
        a_rd_en = pa & ra.rd;  a_wr_en = pa & ra.wr;  a_gm_or_lds = ra.gm;
        a_addr = ra.addr;      a_wr_data = ra.wd;     a_tag = ra.tag;
        b_rd_en = pb & rb.rd;  b_wr_en = pb & rb.wr;  b_gm_or_lds = rb.gm;
        b_addr = rb.addr;      b_wr_data = rb.wd;     b_tag = rb.tag;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pa = 0; pb = 0;
        ra = '{0, 0, 0, 0, 0, 0};
        rb = '{0, 0, 0, 0, 0, 0};
        drive();
        mem_ack = 0; mem_tag_resp = 0; mem_rd_data = 0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        do_reset();
        if (v.is_b) begin rb = v.r; pb = 1; end
        else        begin ra = v.r; pa = 1; end
        drive();
        step();
        chk("vec_mem_rd_en", mem_rd_en, v.exp_rd);
        chk("vec_mem_wr_en", mem_wr_en, v.exp_wr);
        chk("vec_mem_tag_req", mem_tag_req, v.exp_tagreq);
        chk("vec_mem_addr", mem_addr, v.r.addr);
        chk("vec_mem_wr_data", mem_wr_data, v.r.wd);
        chk("vec_mem_gm", mem_gm_or_lds, v.r.gm);
        chk("vec_err", arb_err, v.exp_err);
        for (int d = 0; d < v.delay; d++) begin
            step();
            chk("vec_hold", {mem_rd_en, mem_wr_en, mem_tag_req, mem_addr, a_ack, b_ack},
                {v.exp_rd, v.exp_wr, v.exp_tagreq, v.r.addr, 2'b00});
        end
        mem_ack = 1; mem_tag_resp = v.exp_tagreq; mem_rd_data = v.rdata;
        step();
        mem_ack = 0;
        chk("vec_acks", {a_ack, b_ack}, v.is_b ? 2'b01 : 2'b10);
        chk("vec_rd_data", v.is_b ? b_rd_data : a_rd_data, v.rdata);
        chk("vec_tag_resp", v.is_b ? b_tag_resp : a_tag_resp, v.exp_tagreq[5:0]);
        chk("vec_en_clear", {mem_rd_en, mem_wr_en}, 2'b00);
        pa = 0; pb = 0; drive();
        step();
        chk("vec_idle", {arb_idle, a_ack, b_ack, arb_err}, {1'b1, 2'b00, v.exp_err});
    endtask

    function automatic req_t rand_req();
        req_t r;
        r.rd   = 1'($urandom_range(0, 1));
        r.wr   = r.rd ? ($urandom_range(0, 7) == 0) : 1'b1;
        r.gm   = 1'($urandom_range(0, 1));
        r.addr = $urandom;
        r.wd   = $urandom;
        r.tag  = 6'($urandom_range(0, 63));
        return r;
    endfunction

    vec_t vecs[5];

    initial begin
        vecs[0] = '{0, '{1, 0, 0, 32'h100, 32'h0, 6'd5}, 1, 32'hDEADBEEF, 1, 0, 7'h05, 0};
        vecs[1] = '{1, '{0, 1, 1, 32'h2000, 32'h12345678, 6'h3F}, 10, 32'h0, 0, 1, 7'h7F, 0};
        vecs[2] = '{0, '{1, 1, 0, 32'h44, 32'hAAAA5555, 6'd9}, 0, 32'h600DF00D, 1, 0, 7'h09, 1};
        vecs[3] = '{1, '{1, 0, 0, 32'hFFFFFFFC, 32'h0, 6'h01}, 2, 32'h0, 1, 0, 7'h41, 0};
        vecs[4] = '{0, '{0, 1, 1, 32'h80, 32'hCAFEBABE, 6'h2A}, 3, 32'h13572468, 0, 1, 7'h2A, 0};

        // Reset state
        ra = '{0, 0, 0, 0, 0, 0};
        rb = '{0, 0, 0, 0, 0, 0};
        pa = 0; pb = 0; drive();
        step();
        chk("reset_outputs", {a_ack, b_ack, mem_rd_en, mem_wr_en, mem_gm_or_lds, arb_err,
                              mem_tag_req, mem_addr, a_rd_data, b_tag_resp},
            '0);
        chk("reset_idle", arb_idle, 1'b1);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Exact timing of a single A read
        do_reset();
        ra = '{1, 0, 0, 32'h100, 32'h0, 6'd5}; pa = 1; drive();
        step();
        chk("t1_c1", {mem_rd_en, mem_wr_en, mem_addr, mem_tag_req, arb_idle},
            {2'b10, 32'h100, 7'h05, 1'b0});
        step();
        step();
        mem_ack = 1; mem_tag_resp = 7'h05; mem_rd_data = 32'hDEADBEEF;
        step();
        mem_ack = 0; pa = 0; drive();
        chk("t1_c4", {a_ack, b_ack, a_rd_data, a_tag_resp}, {2'b10, 32'hDEADBEEF, 6'd5});
        step();
        chk("t1_c5", {a_ack, arb_idle, a_rd_data}, {2'b01, 32'hDEADBEEF});

        // Continuous contention: grants alternate A, B, A, B
        do_reset();
        ra = '{1, 0, 0, 32'h10, 0, 6'd1}; rb = '{1, 0, 0, 32'h20, 0, 6'd2};
        pa = 1; pb = 1; drive();
        for (int i = 0; i < 4; i++) begin
            bit o;
            o = bit'(i % 2);
            step();
            chk("rr_owner", mem_tag_req[6], o);
            step();
            chk("rr_no_ack", {a_ack, b_ack}, 2'b00);
            mem_ack = 1; mem_tag_resp = o ? 7'h42 : 7'h01;
            step();
            mem_ack = 0;
            chk("rr_ack", {a_ack, b_ack}, o ? 2'b01 : 2'b10);
            if (o) pb = 0; else pa = 0;
            drive();
            step();
            if (o) pb = 1; else pa = 1;
            drive();
        end

        // Ack carrying the wrong owner id
        do_reset();
        ra = '{1, 0, 0, 32'h300, 0, 6'd5}; pa = 1; drive();
        step();
        mem_ack = 1; mem_tag_resp = 7'h45; mem_rd_data = 32'h1111;
        step();
        mem_ack = 0;
        chk("wid_state", {a_ack, b_ack, mem_rd_en, arb_idle, arb_err}, 5'b00101);
        mem_ack = 1; mem_tag_resp = 7'h05; mem_rd_data = 32'h2222;
        step();
        mem_ack = 0; pa = 0; drive();
        chk("wid_done", {a_ack, b_ack, a_rd_data, arb_err}, {2'b10, 32'h2222, 1'b1});

        // Async reset during ISSUE, then a late ack
        do_reset();
        ra = '{1, 1, 0, 32'h400, 0, 6'd5}; pa = 1; drive();
        step();
        chk("rst_pre", {mem_rd_en, arb_err}, 2'b11);
        rst = 1;
        #1;
        chk("rst_async", {mem_rd_en, arb_idle, arb_err}, 3'b010);
        pa = 0; drive();
        step();
        rst = 0;
        mem_ack = 1; mem_tag_resp = 7'h05; mem_rd_data = 32'h3333;
        step();
        mem_ack = 0;
        chk("rst_late_ack", {a_ack, b_ack, arb_err, arb_idle, a_rd_data}, {4'b0001, 32'h0});

        // Randomized run against a transaction-level model
        do_reset();
        begin
            bit tie_b;
            bit err_m;
            tie_b = 0;
            err_m = 0;
            for (int n = 0; n < 200; n++) begin
                bit o;
                req_t r;
                logic [31:0] rdat;
                if (!pa && $urandom_range(0, 1)) begin ra = rand_req(); pa = 1; end
                if (!pb && $urandom_range(0, 1)) begin rb = rand_req(); pb = 1; end
                if (!pa && !pb) begin
                    if ($urandom_range(0, 1)) begin rb = rand_req(); pb = 1; end
                    else begin ra = rand_req(); pa = 1; end
                end
                drive();
                o = (pa && pb) ? tie_b : pb;
                r = o ? rb : ra;
                err_m |= r.rd & r.wr;
                step();
                chk("rnd_issue", {mem_rd_en, mem_wr_en, mem_tag_req, mem_addr, mem_wr_data,
                                  mem_gm_or_lds},
                    {r.rd, r.wr & ~r.rd, o, r.tag, r.addr, r.wd, r.gm});
                for (int d = $urandom_range(0, 3); d > 0; d--) step();
                rdat = $urandom;
                mem_ack = 1; mem_tag_resp = {o, r.tag}; mem_rd_data = rdat;
                step();
                mem_ack = 0;
                chk("rnd_resp", {a_ack, b_ack, o ? b_rd_data : a_rd_data,
                                 o ? b_tag_resp : a_tag_resp},
                    {~o, o, rdat, r.tag});
                if (o) pb = 0; else pa = 0;
                drive();
                tie_b = ~o;
                step();
                chk("rnd_idle", {arb_idle, a_ack, b_ack, arb_err}, {3'b100, err_m});
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
